// File: rtl/axi_mst_engine.sv
// Single-outstanding AXI master: turns one read/write INCR command into AW/W/B or AR/R
// handshakes, streams beat data through, and reports one registered completion per command.
module axi_mst_engine #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int SIZE       = 3
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    // command interface
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [SIZE:0]           cmd_id,
    input  logic [SIZE:0]           cmd_len,
    // write data stream
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_strb,
    // read data stream
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_last,
    // completion
    output logic                    rsp_valid,
    output logic [SIZE-2:0]         rsp_resp,
    output logic [SIZE:0]           rsp_id,
    output logic                    rsp_err,
    // write address channel
    output logic [ADDR_WIDTH-1:0]   AW_ADDR,
    output logic [SIZE:0]           AW_ID,
    output logic [SIZE:0]           AW_LEN,
    output logic [SIZE-2:0]         AW_BURST,
    output logic [SIZE-1:0]         AW_SIZE,
    output logic                    AWVALID,
    input  logic                    AWREADY,
    // write data channel
    output logic [DATA_WIDTH-1:0]   W_DATA,
    output logic [DATA_WIDTH/8-1:0] W_STRB,
    output logic                    W_LAST,
    output logic [SIZE:0]           W_ID,
    output logic                    WVALID,
    input  logic                    WREADY,
    // write response channel
    input  logic [SIZE:0]           B_ID,
    input  logic [SIZE-2:0]         B_RESP,
    input  logic                    BVALID,
    output logic                    BREADY,
    // read address channel
    output logic [ADDR_WIDTH-1:0]   AR_ADDR,
    output logic [SIZE:0]           AR_ID,
    output logic [SIZE-2:0]         AR_BURST,
    output logic [SIZE:0]           AR_LEN,
    output logic [SIZE-1:0]         AR_SIZE,
    output logic                    AR_VALID,
    input  logic                    AR_READY,
    // read data channel
    input  logic [SIZE:0]           R_ID,
    input  logic [SIZE-2:0]         R_RESP,
    input  logic [DATA_WIDTH-1:0]   R_DATA,
    input  logic                    R_LAST,
    input  logic                    RVALID,
    output logic                    RREADY
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int LSB    = $clog2(STRB_W);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK  = ~((ADDR_WIDTH)'(STRB_W - 1));
    localparam logic [SIZE-2:0]       BURST_INCR = (SIZE-1)'(1);
    localparam logic [SIZE-2:0]       RESP_SLV   = (SIZE-1)'(2);
    localparam logic [SIZE-1:0]       AXSIZE     = (SIZE)'(LSB);
    localparam logic [SIZE:0]         BEAT_ONE   = (SIZE+1)'(1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ADDR = 3'd1,
        WR_DATA = 3'd2,
        WR_RESP = 3'd3,
        RD_ADDR = 3'd4,
        RD_DATA = 3'd5,
        DONE    = 3'd6
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [SIZE:0]           id_q, id_d;
    logic [SIZE:0]           len_q, len_d;
    logic [SIZE:0]           beat_q, beat_d;
    logic [SIZE-2:0]         resp_q, resp_d;
    logic                    err_q, err_d;
    logic                    rsp_valid_q;
    logic [SIZE-2:0]         rsp_resp_q;
    logic [SIZE:0]           rsp_id_q;
    logic                    rsp_err_q;

    logic [ADDR_WIDTH-1:0]   cmd_addr_s;
    logic [15:0]             burst_end_s;
    logic                    cross_4k_s;
    logic                    accept_s;
    logic                    aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s;
    logic                    last_beat_s;

    assign cmd_addr_s  = cmd_addr & ADDR_MASK;
    // End offset of the burst within its 4KB page; anything past 4096 spills into the next page.
    assign burst_end_s = {4'b0000, cmd_addr_s[11:0]} + ((16'(cmd_len) + 16'd1) << LSB);
    assign cross_4k_s  = (burst_end_s > 16'd4096);

    assign accept_s    = cmd_valid & cmd_ready;
    assign aw_hs_s     = (state_q == WR_ADDR) & AWREADY;
    assign w_hs_s      = (state_q == WR_DATA) & wr_valid & WREADY;
    assign b_hs_s      = (state_q == WR_RESP) & BVALID;
    assign ar_hs_s     = (state_q == RD_ADDR) & AR_READY;
    assign r_hs_s      = (state_q == RD_DATA) & RVALID & rd_ready;
    assign last_beat_s = (beat_q == len_q);

    // Next-state, beat counter and response accumulation
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        id_d    = id_q;
        len_d   = len_q;
        beat_d  = beat_q;
        resp_d  = resp_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    addr_d = cmd_addr_s;
                    id_d   = cmd_id;
                    len_d  = cmd_len;
                    beat_d = '0;
                    if (cross_4k_s) begin
                        resp_d  = RESP_SLV;
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        resp_d  = '0;
                        err_d   = 1'b0;
                        state_d = cmd_write ? WR_ADDR : RD_ADDR;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WR_ADDR: begin
                if (aw_hs_s) begin
                    beat_d  = '0;
                    state_d = WR_DATA;
                end else begin
                    state_d = WR_ADDR;
                end
            end
            WR_DATA: begin
                if (w_hs_s) begin
                    if (last_beat_s) begin
                        state_d = WR_RESP;
                    end else begin
                        beat_d = beat_q + BEAT_ONE;
                    end
                end else begin
                    state_d = WR_DATA;
                end
            end
            WR_RESP: begin
                if (b_hs_s) begin
                    resp_d  = B_RESP;
                    err_d   = (B_ID != id_q);
                    state_d = DONE;
                end else begin
                    state_d = WR_RESP;
                end
            end
            RD_ADDR: begin
                if (ar_hs_s) begin
                    beat_d  = '0;
                    state_d = RD_DATA;
                end else begin
                    state_d = RD_ADDR;
                end
            end
            RD_DATA: begin
                if (r_hs_s) begin
                    if (R_RESP > resp_q) begin
                        resp_d = R_RESP;
                    end else begin
                        resp_d = resp_q;
                    end
                    // Sticky: wrong ID, or R_LAST disagreeing with our own beat count.
                    err_d = err_q | (R_ID != id_q) | (R_LAST != last_beat_s);
                    if (last_beat_s) begin
                        state_d = DONE;
                    end else begin
                        beat_d = beat_q + BEAT_ONE;
                    end
                end else begin
                    state_d = RD_DATA;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, captured command fields and registered completion outputs
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            id_q        <= '0;
            len_q       <= '0;
            beat_q      <= '0;
            resp_q      <= '0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_resp_q  <= '0;
            rsp_id_q    <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            id_q        <= id_d;
            len_q       <= len_d;
            beat_q      <= beat_d;
            resp_q      <= resp_d;
            err_q       <= err_d;
            rsp_valid_q <= (state_d == DONE);
            if (state_d == DONE) begin
                rsp_resp_q <= resp_d;
                rsp_id_q   <= id_d;
                rsp_err_q  <= err_d;
            end
        end
    end

    assign cmd_ready = (state_q == IDLE) & ~ARESET;

    assign AWVALID   = (state_q == WR_ADDR);
    assign AW_ADDR   = addr_q;
    assign AW_ID     = id_q;
    assign AW_LEN    = len_q;
    assign AW_BURST  = BURST_INCR;
    assign AW_SIZE   = AXSIZE;

    // Write beats are pure pass-through, gated so nothing leaks out before the AW handshake.
    assign WVALID    = (state_q == WR_DATA) & wr_valid;
    assign wr_ready  = (state_q == WR_DATA) & WREADY;
    assign W_DATA    = (state_q == WR_DATA) ? wr_data : '0;
    assign W_STRB    = (state_q == WR_DATA) ? wr_strb : '0;
    assign W_LAST    = (state_q == WR_DATA) & last_beat_s;
    assign W_ID      = id_q;

    assign BREADY    = (state_q == WR_RESP);

    assign AR_VALID  = (state_q == RD_ADDR);
    assign AR_ADDR   = addr_q;
    assign AR_ID     = id_q;
    assign AR_LEN    = len_q;
    assign AR_BURST  = BURST_INCR;
    assign AR_SIZE   = AXSIZE;

    assign RREADY    = (state_q == RD_DATA) & rd_ready;
    assign rd_valid  = (state_q == RD_DATA) & RVALID;
    assign rd_data   = (state_q == RD_DATA) ? R_DATA : '0;
    assign rd_last   = (state_q == RD_DATA) & R_LAST;

    assign rsp_valid = rsp_valid_q;
    assign rsp_resp  = rsp_resp_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_err   = rsp_err_q;

endmodule
